irq_claim_ctrl: RTL

Core-side claim/complete controller for the EDF interrupt controller. Consumes the combinational winner (valid, priority, index) produced by the interrupt arbiter tree and presents a stable, registered request to the hart. On claim it clears the winning source's pending bit and records the claimed interrupt on a nesting stack. On complete it pops that stack; the top entry sets the preemption threshold for later offers.

---
 rtl/irq_claim_ctrl_if.sv | 51 +++++
 rtl/irq_claim_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/irq_claim_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_claim_ctrl_if
//  Purpose  : Bundles the arbiter-winner inputs, the hart request/claim/
//             complete handshake and the status outputs of irq_claim_ctrl.
//  Ports    : arb_valid_i/arb_prio_i/arb_idx_i   - arbiter winner
//             ip_clr_o                           - pending-bit clear pulse
//             irq_valid_o/irq_id_o/irq_prio_o    - request offered to hart
//             irq_ack_i                          - hart claims the offer
//             irq_cmpl_i/irq_cmpl_id_i           - hart completes an ID
//             depth_o/cur_prio_o/err_o           - nesting status, error
//  Modports : master = controller side, slave = arbiter/hart side.
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_claim_ctrl_if #(
  parameter int NrInputs  = 32,
  parameter int PrioWidth = 8,
  parameter int NestDepth = 4
);
  localparam int IdxWidth   = $clog2(NrInputs);
  localparam int DepthWidth = $clog2(NestDepth + 1);

  logic                  arb_valid_i;
  logic [PrioWidth-1:0]  arb_prio_i;
  logic [IdxWidth-1:0]   arb_idx_i;
  logic [NrInputs-1:0]   ip_clr_o;
  logic                  irq_valid_o;
  logic [IdxWidth-1:0]   irq_id_o;
  logic [PrioWidth-1:0]  irq_prio_o;
  logic                  irq_ack_i;
  logic                  irq_cmpl_i;
  logic [IdxWidth-1:0]   irq_cmpl_id_i;
  logic [DepthWidth-1:0] depth_o;
  logic [PrioWidth-1:0]  cur_prio_o;
  logic                  err_o;

  modport master (
    input  arb_valid_i, arb_prio_i, arb_idx_i,
    input  irq_ack_i, irq_cmpl_i, irq_cmpl_id_i,
    output ip_clr_o, irq_valid_o, irq_id_o, irq_prio_o,
    output depth_o, cur_prio_o, err_o
  );

  modport slave (
    output arb_valid_i, arb_prio_i, arb_idx_i,
    output irq_ack_i, irq_cmpl_i, irq_cmpl_id_i,
    input  ip_clr_o, irq_valid_o, irq_id_o, irq_prio_o,
    input  depth_o, cur_prio_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/irq_claim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_claim_ctrl
//  Purpose  : Claim/complete controller for the EDF interrupt controller.
//             Latches the arbiter winner into a stable request for the hart,
//             clears the claimed source's pending bit, and tracks nested
//             in-service interrupts on a stack whose top sets the preemption
//             threshold for later offers.
//  Ports    : clk_i  - clock
//             rst_i  - asynchronous, active-high reset
//             bus    - irq_claim_ctrl_if.master (arbiter, hart, status)
//  Revision : 1.0 - initial release
// ============================================================================
module irq_claim_ctrl #(
  parameter int NrInputs  = 32,
  parameter int PrioWidth = 8,
  parameter int NestDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  irq_claim_ctrl_if.master    bus
);
  localparam int IdxWidth   = $clog2(NrInputs);
  localparam int DepthWidth = $clog2(NestDepth + 1);

  localparam logic [DepthWidth-1:0] c_nest_depth = DepthWidth'(NestDepth);
  localparam logic [DepthWidth-1:0] c_depth_one  = DepthWidth'(1);
  localparam logic [NrInputs-1:0]   c_clr_one    = NrInputs'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Nesting stack; entry 0 is the bottom, entry r_depth-1 is the top.
  logic [PrioWidth-1:0]  r_stk_prio [NestDepth];
  logic [IdxWidth-1:0]   r_stk_idx  [NestDepth];
  logic [DepthWidth-1:0] r_depth;

  logic                  r_irq_valid;
  logic [IdxWidth-1:0]   r_irq_id;
  logic [PrioWidth-1:0]  r_irq_prio;
  logic [NrInputs-1:0]   r_ip_clr;
  logic [PrioWidth-1:0]  r_cur_prio;
  logic                  r_err;

  logic [PrioWidth-1:0]  w_top_prio;
  logic [IdxWidth-1:0]   w_top_idx;
  logic [PrioWidth-1:0]  w_below_prio;
  logic                  w_nonempty;
  logic                  w_eligible;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cmpl_bad;
  logic [DepthWidth-1:0] w_wr_ptr;
  logic [DepthWidth-1:0] w_depth_nxt;

  // Top-of-stack and the entry beneath it, read through a compare mux so the
  // depth counter (one bit wider than the entry index) never indexes directly.
  always_comb begin
    w_top_prio   = '0;
    w_top_idx    = '0;
    w_below_prio = '0;
    for (int i = 0; i < NestDepth; i++) begin
      if (r_depth == DepthWidth'(i + 1)) begin
        w_top_prio = r_stk_prio[i];
        w_top_idx  = r_stk_idx[i];
      end
    end
    for (int i = 0; i < NestDepth - 1; i++) begin
      if (r_depth == DepthWidth'(i + 2)) begin
        w_below_prio = r_stk_prio[i];
      end
    end
  end

  assign w_nonempty = (r_depth != '0);

  // Equal priority never preempts: strictly smaller (signed) value required.
  assign w_eligible = bus.arb_valid_i && (r_depth < c_nest_depth) &&
                      (!w_nonempty ||
                       ($signed(bus.arb_prio_i) < $signed(w_top_prio)));

  assign w_pop      = bus.irq_cmpl_i && w_nonempty &&
                      (bus.irq_cmpl_id_i == w_top_idx);
  assign w_cmpl_bad = bus.irq_cmpl_i && !w_pop;
  assign w_push     = (r_state == ST_OFFER) && bus.irq_ack_i;

  // Pop is applied before push: a simultaneous pop/push overwrites the top.
  assign w_wr_ptr = w_pop ? (r_depth - c_depth_one) : r_depth;

  always_comb begin
    w_depth_nxt = r_depth;
    if (w_push && !w_pop) begin
      w_depth_nxt = r_depth + c_depth_one;
    end else if (w_pop && !w_push) begin
      w_depth_nxt = r_depth - c_depth_one;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_eligible)    w_state_nxt = ST_OFFER;
      ST_OFFER: if (bus.irq_ack_i) w_state_nxt = ST_CLEAR;
      ST_CLEAR: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
      r_irq_prio  <= '0;
      r_ip_clr    <= '0;
      r_cur_prio  <= '0;
      r_err       <= 1'b0;
      r_depth     <= '0;
    end else begin
      r_err    <= w_cmpl_bad;
      r_ip_clr <= w_push ? (c_clr_one << r_irq_id) : '0;
      r_depth  <= w_depth_nxt;

      if ((r_state == ST_IDLE) && w_eligible) begin
        r_irq_valid <= 1'b1;
        r_irq_id    <= bus.arb_idx_i;
        r_irq_prio  <= bus.arb_prio_i;
      end else if (w_push) begin
        r_irq_valid <= 1'b0;
      end

      // w_below_prio reads 0 at depth 1, so popping the last entry yields 0.
      if (w_push) begin
        r_cur_prio <= r_irq_prio;
      end else if (w_pop) begin
        r_cur_prio <= w_below_prio;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NestDepth; i++) begin
        r_stk_prio[i] <= '0;
        r_stk_idx[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NestDepth; i++) begin
        if (w_push && (w_wr_ptr == DepthWidth'(i))) begin
          r_stk_prio[i] <= r_irq_prio;
          r_stk_idx[i]  <= r_irq_id;
        end
      end
    end
  end

  assign bus.ip_clr_o    = r_ip_clr;
  assign bus.irq_valid_o = r_irq_valid;
  assign bus.irq_id_o    = r_irq_id;
  assign bus.irq_prio_o  = r_irq_prio;
  assign bus.depth_o     = r_depth;
  assign bus.cur_prio_o  = r_cur_prio;
  assign bus.err_o       = r_err;

`ifndef SYNTHESIS
  // Eligibility excludes offers while full, so a net push can never overflow.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_depth == c_nest_depth)));
`endif

endmodule
`default_nettype wire
